// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP solver and its result monitor.
package dsp_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  // Width of the DSP solver output word
  localparam int DSP_DATA_W  = 12;
  // Solver output value that marks a completed solve
  localparam int DSP_TARGET  = 1640;
  // Default width of the cycle counter
  localparam int DSP_CNT_W   = 16;
  // Default cycle limit for one measurement
  localparam int DSP_TIMEOUT = 1000;

endpackage

// File: rtl/cycle_counter.sv
// Cycle counter for the result monitor: synchronous clear, count enable,
// a pre-computed next value and a flag that the next increment reaches TIMEOUT.
module cycle_counter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_next_o,
  output logic             terminal_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over enable; otherwise hold
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_next_o;
    end
  end

  // Counter register, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The value the counter takes on the next increment, and whether that
  // value equals the cycle limit; TIMEOUT < 2^CNT_W so this never wraps
  assign count_next_o = count_q + CNT_W'(1);
  assign terminal_o   = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dsp_result_monitor.sv
// Enables the DSP solver, counts cycles until solved_dsp equals TARGET,
// latches result and cycle count, and holds done/timeout until acknowledged.
module dsp_result_monitor
  import dsp_pkg::*;
#(
  parameter int DATA_W  = DSP_DATA_W,
  parameter int CNT_W   = DSP_CNT_W,
  parameter int TARGET  = DSP_TARGET,
  parameter int TIMEOUT = DSP_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] solved_dsp,
  input  logic              ack_i,
  output logic              dsp_ena,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] result_o,
  output logic [CNT_W-1:0]  cycles_o
);

  state_e state_q;
  state_e state_d;

  logic              dsp_ena_q;
  logic              dsp_ena_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;
  logic              timeout_q;
  logic              timeout_d;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] result_d;
  logic [CNT_W-1:0]  cycles_q;
  logic [CNT_W-1:0]  cycles_d;

  logic              match;
  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_next;
  logic              cnt_terminal;

  assign match   = (solved_dsp == DATA_W'(TARGET));
  assign cnt_clr = (state_q == ST_IDLE) && start_i;
  assign cnt_en  = (state_q == ST_RUN);

  cycle_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cycle_counter (
    .clk          (clk),
    .rst_n        (rst),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .count_next_o (cnt_next),
    .terminal_o   (cnt_terminal)
  );

  // State register; reset aborts any measurement in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a match takes priority over hitting the cycle limit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (match) begin
          state_d = ST_DONE;
        end else if (cnt_terminal) begin
          state_d = ST_FAIL;
        end
      end
      ST_DONE: if (ack_i) state_d = ST_IDLE;
      ST_FAIL: if (ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values: flags follow the state being entered, data is
  // captured only on the edge that ends a run
  always_comb begin
    dsp_ena_d = (state_d == ST_RUN);
    busy_d    = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    timeout_d = (state_d == ST_FAIL);
    result_d  = result_q;
    cycles_d  = cycles_q;
    if (state_q == ST_RUN) begin
      if (match) begin
        result_d = solved_dsp;
        cycles_d = cnt_next;
      end else if (cnt_terminal) begin
        cycles_d = CNT_W'(TIMEOUT);
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dsp_ena_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      cycles_q  <= '0;
    end else begin
      dsp_ena_q <= dsp_ena_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      cycles_q  <= cycles_d;
    end
  end

  assign dsp_ena   = dsp_ena_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign result_o  = result_q;
  assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_dsp_result_monitor.sv
// Directed and randomized checks of dsp_result_monitor against a simple
// "first matching edge, else timeout" reference model.
module tb_dsp_result_monitor;

  localparam int DATA_W  = 12;
  localparam int CNT_W   = 16;
  localparam int TARGET  = 1640;
  localparam int TIMEOUT = 1000;
  localparam int NEVER   = 1000000;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [DATA_W-1:0] solved_dsp;
  logic              ack_i;
  logic              dsp_ena;
  logic              busy_o;
  logic              done_o;
  logic              timeout_o;
  logic [DATA_W-1:0] result_o;
  logic [CNT_W-1:0]  cycles_o;

  int checks = 0;
  int errors = 0;

  // reference model of the latched data
  int m_result = 0;
  int m_cycles = 0;

  dsp_result_monitor #(
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .TARGET  (TARGET),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .solved_dsp (solved_dsp),
    .ack_i      (ack_i),
    .dsp_ena    (dsp_ena),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .timeout_o  (timeout_o),
    .result_o   (result_o),
    .cycles_o   (cycles_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] noise();
    logic [DATA_W-1:0] v;
    v = DATA_W'($urandom_range(0, 4095));
    if (v == DATA_W'(TARGET)) v = '0;
    return v;
  endfunction

  task automatic chk_all(input string tag, input int ena, input int busy, input int done, input int tmo);
    chk({tag, ".dsp_ena"}, int'(dsp_ena), ena);
    chk({tag, ".busy"}, int'(busy_o), busy);
    chk({tag, ".done"}, int'(done_o), done);
    chk({tag, ".timeout"}, int'(timeout_o), tmo);
    chk({tag, ".result"}, int'(result_o), m_result);
    chk({tag, ".cycles"}, int'(cycles_o), m_cycles);
  endtask

  // One measurement: the stub shows TARGET first at RUN edge match_edge
  // (NEVER = not at all); start_i is re-pulsed at RUN edge restart_edge.
  task automatic do_run(input string tag, input int match_edge, input int restart_edge);
    bit exp_done;
    int last;
    exp_done = (match_edge >= 1) && (match_edge <= TIMEOUT);
    last     = exp_done ? match_edge : TIMEOUT;
    solved_dsp = noise();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, ".E0.dsp_ena"}, int'(dsp_ena), 1);
    chk({tag, ".E0.busy"}, int'(busy_o), 1);
    for (int k = 1; k <= last; k++) begin
      solved_dsp = (k == match_edge) ? DATA_W'(TARGET) : noise();
      start_i    = (k == restart_edge);
      tick();
      if (k == last - 1) begin
        chk({tag, ".pre.busy"}, int'(busy_o), 1);
      end
    end
    start_i = 1'b0;
    solved_dsp = noise();
    if (exp_done) begin
      m_result = TARGET;
      m_cycles = match_edge;
    end else begin
      m_cycles = TIMEOUT;
    end
    chk_all({tag, ".end"}, 0, 0, exp_done ? 1 : 0, exp_done ? 0 : 1);
    $display("run %s match_edge=%0d done=%0b timeout=%0b cycles=%0d result=%0d",
             tag, match_edge, done_o, timeout_o, cycles_o, result_o);
  endtask

  task automatic do_ack(input string tag);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk_all({tag, ".ack"}, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_result = 0;
    m_cycles = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst        = 1'b0;
    start_i    = 1'b0;
    ack_i      = 1'b0;
    solved_dsp = '0;
    #3;
    chk_all("reset", 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk_all("idle", 0, 0, 0, 0);

    // ack in IDLE is ignored
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk_all("idle_ack", 0, 0, 0, 0);

    // match at edge 37
    do_run("t1", 37, 0);
    do_ack("t1");

    // no match after a fresh reset: timeout at 1000, result stays 0
    do_reset();
    do_run("t2", NEVER, 0);
    do_ack("t2");

    // match exactly on the timeout edge: done wins
    do_run("t3", TIMEOUT, 0);
    do_ack("t3");

    // asynchronous reset at RUN cycle 20
    solved_dsp = noise();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      solved_dsp = noise();
      tick();
    end
    chk("t4.busy_before_rst", int'(busy_o), 1);
    rst = 1'b0;
    m_result = 0;
    m_cycles = 0;
    #2;
    chk_all("t4.async", 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    do_run("t4", 37, 0);

    // DONE holds without ack
    for (int i = 0; i < 10; i++) begin
      ack_i = 1'b0;
      start_i = 1'b0;
      tick();
      chk_all("t5.hold", 0, 0, 1, 0);
    end
    // start together with ack: back to IDLE, no new run
    start_i = 1'b1;
    ack_i = 1'b1;
    tick();
    start_i = 1'b0;
    ack_i = 1'b0;
    chk_all("t5.start_ack", 0, 0, 0, 0);
    tick();
    chk_all("t5.no_run", 0, 0, 0, 0);
    do_run("t5", 9, 0);
    do_ack("t5");

    // start re-pulsed mid-run does not restart the count
    do_run("t6", 12, 5);
    do_ack("t6");

    // randomized runs, some past the timeout
    for (int r = 0; r < 6; r++) begin
      int m;
      m = $urandom_range(1, TIMEOUT + 60);
      do_run("rand", m, $urandom_range(1, 20));
      // hold a few random cycles before acking
      for (int i = 0, n = $urandom_range(0, 3); i < n; i++) begin
        tick();
      end
      chk("rand.hold.done", int'(done_o), (m <= TIMEOUT) ? 1 : 0);
      do_ack("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
